// File: rtl/exc_vector_seq.sv
// Multicycle exception sequencer: save EPC, read the cause's vector byte, load the handler PC.
// Optional software-visible cause register is enabled by defining EXC_CAUSE_REG_EN.
module exc_vector_seq #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        opcode_req,
  input  logic        ovf_req,
  input  logic        div0_req,
  input  logic [31:0] mem_data_in,
  output logic        exc_busy,
  output logic [2:0]  mem_addr_sel,
  output logic        mem_read,
  output logic        epc_write,
  output logic        pc_write,
  output logic [31:0] handler_pc,
  output logic        exc_done,
  output logic [1:0]  exc_cause
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SAVE  = 2'd1,
    S_FETCH = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_OPCODE = 2'd1,
    C_OVF    = 2'd2,
    C_DIV0   = 2'd3
  } cause_t;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("exc_vector_seq: MEM_LATENCY must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t     state_q, state_d;
  cause_t     cause_q, cause_d;
  logic [3:0] cnt_q, cnt_d;
  cause_t     req_cause;

  // Only the handler byte is architecturally used; upper read data is ignored.
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data_in[31:8];

  always_comb begin
    req_cause = C_NONE;
    if (opcode_req)    req_cause = C_OPCODE;
    else if (ovf_req)  req_cause = C_OVF;
    else if (div0_req) req_cause = C_DIV0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    exc_busy     = 1'b0;
    mem_addr_sel = 3'd0;
    mem_read     = 1'b0;
    epc_write    = 1'b0;
    pc_write     = 1'b0;
    exc_done     = 1'b0;
    handler_pc   = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (req_cause != C_NONE) begin
          cause_d = req_cause;
          state_d = S_SAVE;
        end
      end
      S_SAVE: begin
        exc_busy  = 1'b1;
        epc_write = 1'b1;
        cnt_d     = CNT_INIT;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        exc_busy     = 1'b1;
        mem_read     = 1'b1;
        mem_addr_sel = 3'd3 + {1'b0, cause_q};
        if (cnt_q == 4'd0) state_d = S_LOAD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_LOAD: begin
        exc_busy     = 1'b1;
        mem_addr_sel = 3'd3 + {1'b0, cause_q};
        pc_write     = 1'b1;
        exc_done     = 1'b1;
        handler_pc   = {24'd0, mem_data_in[7:0]};
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The vector cause register already holds the last accepted cause until
  // the next accept or reset, so it doubles as the software-visible copy.
`ifdef EXC_CAUSE_REG_EN
  assign exc_cause = cause_q;
`else
  assign exc_cause = 2'b00;
`endif

endmodule

// File: tb/tb_exc_vector_seq.sv
// Self-checking bench for exc_vector_seq: directed stimulus plus a scoreboard
// of expected handler loads compared whenever the DUT asserts pc_write.
module tb_exc_vector_seq;

  typedef struct {
    logic [31:0] handler;
    logic [2:0]  sel;
    logic [1:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        opcode_req, ovf_req, div0_req;
  logic        opcode_req3;
  logic        zero = 1'b0;
  logic [31:0] mem_data_in;

  logic        busy1, rd1, epc1, pw1, done1;
  logic [2:0]  sel1;
  logic [31:0] hpc1;
  logic [1:0]  cause1;

  logic        busy3, rd3, epc3, pw3, done3;
  logic [2:0]  sel3;
  logic [31:0] hpc3;
  logic [1:0]  cause3;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  exc_vector_seq #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .opcode_req(opcode_req), .ovf_req(ovf_req),
    .div0_req(div0_req), .mem_data_in(mem_data_in), .exc_busy(busy1),
    .mem_addr_sel(sel1), .mem_read(rd1), .epc_write(epc1), .pc_write(pw1),
    .handler_pc(hpc1), .exc_done(done1), .exc_cause(cause1)
  );

  exc_vector_seq #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .opcode_req(opcode_req3), .ovf_req(zero),
    .div0_req(zero), .mem_data_in(mem_data_in), .exc_busy(busy3),
    .mem_addr_sel(sel3), .mem_read(rd3), .epc_write(epc3), .pc_write(pw3),
    .handler_pc(hpc3), .exc_done(done3), .exc_cause(cause3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] cexp(input logic [1:0] c);
`ifdef EXC_CAUSE_REG_EN
    return c;
`else
    return 2'b00;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard consumer: every pc_write on the latency-1 instance must match a queued load.
  always @(negedge clk) begin
    if (pw1) begin
      if (sb_q.size() == 0) begin
        check("pc_write_unexpected", pw1, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_handler_pc", hpc1, e.handler);
        check("sb_sel", sel1, e.sel);
        check("sb_cause", cause1, e.cause);
        check("sb_done_with_pc_write", done1, 1'b1);
      end
    end
    if (done1) n_done++;
  end

  initial begin
    int done_before, cnt_rd, cnt_busy, cnt_pw;
    reset = 1'b1; opcode_req = 0; ovf_req = 0; div0_req = 0; opcode_req3 = 0;
    mem_data_in = 32'd0;

    // Reset held two cycles.
    tick(); tick();
    check("rst_busy", busy1, 0);
    check("rst_sel", sel1, 0);
    check("rst_rd", rd1, 0);
    check("rst_epc", epc1, 0);
    check("rst_pw", pw1, 0);
    check("rst_done", done1, 0);
    check("rst_hpc", hpc1, 0);
    check("rst_cause", cause1, 0);
    check("rst_busy3", busy3, 0);
    reset = 1'b0;
    mem_data_in = 32'hFFFF_FF12;
    tick();

    // Single overflow pulse, latency 1.
    ovf_req = 1'b1;
    sb_q.push_back('{32'h12, 3'd5, cexp(2'd2)});
    tick();
    check("ovf_save_epc", epc1, 1);
    check("ovf_save_busy", busy1, 1);
    check("ovf_save_sel", sel1, 0);
    check("ovf_save_rd", rd1, 0);
    ovf_req = 1'b0;
    tick();
    check("ovf_fetch_sel", sel1, 5);
    check("ovf_fetch_rd", rd1, 1);
    check("ovf_fetch_epc", epc1, 0);
    check("ovf_fetch_pw", pw1, 0);
    check("ovf_fetch_hpc", hpc1, 0);
    tick();
    check("ovf_load_pw", pw1, 1);
    check("ovf_load_done", done1, 1);
    check("ovf_load_hpc", hpc1, 32'h12);
    tick();
    check("ovf_idle_busy", busy1, 0);
    check("ovf_idle_hpc", hpc1, 0);
    check("ovf_idle_cause_held", cause1, cexp(2'd2));

    // Simultaneous opcode and div0: opcode wins.
    mem_data_in = 32'h0000_00A7;
    opcode_req = 1'b1; div0_req = 1'b1;
    sb_q.push_back('{32'hA7, 3'd4, cexp(2'd1)});
    tick();
    opcode_req = 1'b0; div0_req = 1'b0;
    tick();
    check("prio_fetch_sel", sel1, 4);
    check("prio_fetch_cause", cause1, cexp(2'd1));
    tick(); tick();
    check("prio_idle_busy", busy1, 0);

    // div0 pulse during an overflow FETCH is dropped.
    mem_data_in = 32'h0000_005C;
    done_before = n_done;
    ovf_req = 1'b1;
    sb_q.push_back('{32'h5C, 3'd5, cexp(2'd2)});
    tick();
    ovf_req = 1'b0;
    tick();
    div0_req = 1'b1;
    tick();
    check("ign_load_sel_held", sel1, 5);
    div0_req = 1'b0;
    tick();
    check("ign_idle_busy", busy1, 0);
    tick(); tick();
    check("ign_busy_later", busy1, 0);
    check("ign_one_done", n_done - done_before, 1);
    check("ign_cause", cause1, cexp(2'd2));

    // Reset during FETCH aborts without a PC load.
    ovf_req = 1'b1;
    tick();
    ovf_req = 1'b0;
    tick();
    check("abort_fetch_rd", rd1, 1);
    reset = 1'b1;
    tick();
    check("abort_busy", busy1, 0);
    check("abort_sel", sel1, 0);
    check("abort_pw", pw1, 0);
    check("abort_cause", cause1, 0);
    reset = 1'b0;
    tick(); tick();
    check("abort_pw_later", pw1, 0);
    check("abort_busy_later", busy1, 0);

    // Held div0 request restarts a sequence once back in IDLE.
    mem_data_in = 32'h0000_0033;
    done_before = n_done;
    sb_q.push_back('{32'h33, 3'd6, cexp(2'd3)});
    sb_q.push_back('{32'h33, 3'd6, cexp(2'd3)});
    div0_req = 1'b1;
    repeat (8) tick();
    div0_req = 1'b0;
    repeat (4) tick();
    check("held_two_done", n_done - done_before, 2);
    check("held_idle_busy", busy1, 0);

    // Latency-3 instance: read strobe and busy window lengths.
    mem_data_in = 32'h0000_009E;
    cnt_rd = 0; cnt_busy = 0; cnt_pw = 0;
    opcode_req3 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) opcode_req3 = 1'b0;
      if (rd3)   cnt_rd++;
      if (busy3) cnt_busy++;
      if (pw3) begin
        cnt_pw++;
        check("lat3_hpc", hpc3, 32'h9E);
        check("lat3_sel", sel3, 4);
      end
    end
    check("lat3_rd_cycles", cnt_rd, 3);
    check("lat3_busy_cycles", cnt_busy, 5);
    check("lat3_pw_count", cnt_pw, 1);

    repeat (2) tick();
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
